// File: rtl/spdif_frame_scheduler_if.sv
// Stream bundle between audio source, frame scheduler and sub-frame encoder.
// slave = scheduler side, master = source/encoder environment side.
interface spdif_frame_scheduler_if #(
  parameter int audio_width = 24
);
  logic                   i_valid;
  logic                   i_ready;
  logic [audio_width-1:0] i_left;
  logic [audio_width-1:0] i_right;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_is_frame_start;
  logic                   o_is_left;
  logic [audio_width-1:0] o_audio;
  logic                   o_user;
  logic                   o_control;

  modport master (
    output i_valid, i_left, i_right, o_ready,
    input  i_ready, o_valid, o_is_frame_start,
    input  o_is_left, o_audio, o_user, o_control
  );

  modport slave (
    input  i_valid, i_left, i_right, o_ready,
    output i_ready, o_valid, o_is_frame_start,
    output o_is_left, o_audio, o_user, o_control
  );
endinterface

// File: rtl/spdif_frame_scheduler.sv
// Orders stereo pairs into L/R sub-frames, tracks the 192-frame block,
// serializes channel status and fills source underruns with silence.
module spdif_frame_scheduler #(
  parameter int audio_width = 24
) (
  input  logic       clk128,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic       cfg_copy,
  input  logic [7:0] cfg_category,
  input  logic [3:0] cfg_fs,
  input  logic [3:0] cfg_word_len,
  output logic       o_underrun,
  output logic [7:0] o_frame_index,
  spdif_frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_L,
    SEND_R
  } state_t;

  state_t state_q, state_d;

  logic                   buf_full_q;
  logic [audio_width-1:0] buf_l_q, buf_r_q;
  logic [audio_width-1:0] out_l_q, out_r_q;
  logic [7:0]             idx_q;
  logic                   copy_q;
  logic [7:0]             cat_q;
  logic [3:0]             fs_q, wl_q;

  logic        accept;
  logic        start;
  logic        frame_done;
  logic        wrap;
  logic        latch_cfg;
  logic [63:0] cs;

  assign accept      = bus.i_valid && !buf_full_q;
  assign bus.i_ready = !buf_full_q;
  assign wrap        = (idx_q == 8'd191);
  assign frame_done  = (state_q == SEND_R) && bus.o_ready;
  assign latch_cfg   = start || (frame_done && wrap);

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    o_underrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_enable && (buf_full_q || accept)) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      LOAD: begin
        state_d    = SEND_L;
        o_underrun = !buf_full_q && !accept;
      end
      SEND_L: begin
        if (bus.o_ready) state_d = SEND_R;
      end
      SEND_R: begin
        if (bus.o_ready) state_d = i_enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // LOAD drains the buffer first; otherwise a pair arriving now bypasses it.
  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) begin
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
    end else if (state_q == LOAD) begin
      if (buf_full_q) begin
        out_l_q    <= buf_l_q;
        out_r_q    <= buf_r_q;
        buf_full_q <= 1'b0;
      end else if (accept) begin
        out_l_q <= bus.i_left;
        out_r_q <= bus.i_right;
      end else begin
        out_l_q <= '0;
        out_r_q <= '0;
      end
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_l_q    <= bus.i_left;
      buf_r_q    <= bus.i_right;
    end
  end

  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      copy_q <= 1'b0;
      cat_q  <= '0;
      fs_q   <= '0;
      wl_q   <= '0;
    end else begin
      if (start)           idx_q <= '0;
      else if (frame_done) idx_q <= wrap ? 8'd0 : idx_q + 8'd1;
      if (latch_cfg) begin
        copy_q <= cfg_copy;
        cat_q  <= cfg_category;
        fs_q   <= cfg_fs;
        wl_q   <= cfg_word_len;
      end
    end
  end

  // Only bits 0..63 of the 192-bit status block can be non-zero.
  always_comb begin
    cs        = '0;
    cs[2]     = copy_q;
    cs[15:8]  = cat_q;
    cs[27:24] = fs_q;
    cs[35:32] = wl_q;
  end

  assign bus.o_control = (idx_q[7:6] == 2'b00) && cs[idx_q[5:0]];

  assign bus.o_valid = (state_q == SEND_L) || (state_q == SEND_R);
  assign bus.o_is_left = (state_q == SEND_L);
  assign bus.o_is_frame_start = (state_q == SEND_L) && (idx_q == 8'd0);
  assign bus.o_audio = (state_q == SEND_L) ? out_l_q : out_r_q;
  assign bus.o_user = 1'b0;
  assign o_frame_index = idx_q;

endmodule
